// File: rtl/stub_link_tx_if.sv
// Handshake and data bundle between the stub FIFO, the link transmitter and its controller.
// The master side drives the controls and FIFO data; the slave side is the transmitter.
interface stub_link_tx_if;
  logic        en_proc;
  logic        start;
  logic        done;
  logic [35:0] data_in;
  logic        empty;
  logic        read_en;
  logic [31:0] data_out1;
  logic [31:0] data_out2;

  modport master (
    output en_proc, start, data_in, empty,
    input  done, read_en, data_out1, data_out2
  );

  modport slave (
    input  en_proc, start, data_in, empty,
    output done, read_en, data_out1, data_out2
  );
endinterface

// File: rtl/stub_link_tx.sv
// Stub link transmitter: drains 36-bit stubs from the upstream FIFO during a fixed read window.
// Each stub goes out as two framed 32-bit link words, and a trailer word pair closes every event.
module stub_link_tx #(
  parameter int NCYCLE    = 100,
  parameter int MAX_STUBS = 1023,
  parameter int CNT_W     = 10
) (
  input logic           clk,
  input logic           reset,
  stub_link_tx_if.slave bus
);

  localparam int CYC_W = (NCYCLE > 1) ? $clog2(NCYCLE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    TRAIL
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CYC_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stub_cnt;
  logic [CNT_W-1:0] issued;
  logic [2:0]       bx;
  logic             rd_q;
  logic             rd_en;
  logic             last_cycle;
  logic             start_evt;
  logic             trail_go;
  logic [9:0]       idx;

  assign last_cycle = (cycle_cnt == CYC_W'(NCYCLE - 1));
  assign start_evt  = (state == IDLE) && bus.start && bus.en_proc;
  assign trail_go   = (state == TRAIL) && bus.en_proc;
  assign idx        = 10'(stub_cnt);
  assign bus.read_en = rd_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Every state transition waits for en_proc, so a paused link freezes the event in place.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && bus.en_proc) state_nxt = RUN;
      end
      RUN: begin
        if (bus.en_proc) begin
          rd_en = ~bus.empty && (issued < CNT_W'(MAX_STUBS));
          if (last_cycle) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.en_proc) state_nxt = TRAIL;
      end
      TRAIL: begin
        if (bus.en_proc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      issued    <= '0;
      stub_cnt  <= '0;
      bx        <= '0;
    end else begin
      if (start_evt) begin
        cycle_cnt <= '0;
        issued    <= '0;
      end else if ((state == RUN) && bus.en_proc) begin
        cycle_cnt <= cycle_cnt + CYC_W'(1);
        if (rd_en) issued <= issued + CNT_W'(1);
      end
      // A read already in flight is emitted even while en_proc is low, so the index must follow it.
      if (start_evt) begin
        stub_cnt <= '0;
      end else if (rd_q) begin
        stub_cnt <= stub_cnt + CNT_W'(1);
      end
      if (trail_go) bx <= bx + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q          <= 1'b0;
      bus.done      <= 1'b0;
      bus.data_out1 <= '0;
      bus.data_out2 <= '0;
    end else begin
      rd_q     <= rd_en;
      bus.done <= trail_go;
      if (rd_q) begin
        bus.data_out1 <= {bus.data_in[35:18], 1'b1, bx, idx};
        bus.data_out2 <= {bus.data_in[17:0], 1'b1, bx, idx};
      end else if (trail_go) begin
        bus.data_out1 <= {18'h3FFFF, 1'b0, bx, idx};
        bus.data_out2 <= {18'h3FFFF, 1'b0, bx, idx};
      end else begin
        bus.data_out1 <= '0;
        bus.data_out2 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stub_link_tx.sv
// Randomised bench for stub_link_tx: a queue-backed FIFO feeds the DUT, and an event-level
// model (window length, tail length, stub counts) predicts read_en and every output word.
module tb_stub_link_tx;
  localparam int NCYCLE    = 10;
  localparam int MAX_STUBS = 4;
  localparam int CNT_W     = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stub_link_tx_if bus ();

  stub_link_tx #(
    .NCYCLE   (NCYCLE),
    .MAX_STUBS(MAX_STUBS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [35:0] fifo[$];

  bit          busy;
  int          win_left;
  int          tail_left;
  int          issued;
  int          emitted;
  int          bx;
  bit          pend;
  logic [35:0] pend_data;
  logic [31:0] exp_o1;
  logic [31:0] exp_o2;
  logic        exp_done;

  task automatic check_output(input string tag, input logic [35:0] got, input logic [35:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [35:0] rand36();
    return {4'($urandom), 32'($urandom)};
  endfunction

  task automatic check_outputs_now();
    check_output("data_out1", 36'(bus.data_out1), 36'(exp_o1));
    check_output("data_out2", 36'(bus.data_out2), 36'(exp_o2));
    check_output("done", 36'(bus.done), 36'(exp_done));
  endtask

  task automatic model_clear();
    busy      = 1'b0;
    win_left  = 0;
    tail_left = 0;
    issued    = 0;
    emitted   = 0;
    bx        = 0;
    pend      = 1'b0;
    exp_o1    = '0;
    exp_o2    = '0;
    exp_done  = 1'b0;
  endtask

  // One clock cycle: check last edge's outputs, drive inputs, check read_en, advance the model.
  task automatic apply_stimulus(input bit st, input bit en, input bit hold_empty);
    bit rd;
    bit trail_now;
    @(negedge clk);
    check_outputs_now();
    bus.start   = st;
    bus.en_proc = en;
    bus.data_in = pend ? pend_data : rand36();
    bus.empty   = hold_empty || (fifo.size() == 0);
    trail_now = busy && en && (win_left == 0) && (tail_left == 1);
    rd = busy && en && (win_left > 0) && !bus.empty && (issued < MAX_STUBS);
    #1;
    check_output("read_en", 36'(bus.read_en), 36'(rd));
    exp_done = trail_now;
    if (pend) begin
      exp_o1 = {pend_data[35:18], 1'b1, 3'(bx), 10'(emitted)};
      exp_o2 = {pend_data[17:0], 1'b1, 3'(bx), 10'(emitted)};
      emitted++;
    end else if (trail_now) begin
      exp_o1 = {18'h3FFFF, 1'b0, 3'(bx), 10'(emitted)};
      exp_o2 = exp_o1;
    end else begin
      exp_o1 = '0;
      exp_o2 = '0;
    end
    pend = rd;
    if (rd) begin
      pend_data = fifo.pop_front();
      issued++;
    end
    if (!busy) begin
      if (st && en) begin
        busy      = 1'b1;
        win_left  = NCYCLE;
        tail_left = 2;
        issued    = 0;
        emitted   = 0;
      end
    end else if (en) begin
      if (win_left > 0) begin
        win_left--;
      end else begin
        tail_left--;
        if (tail_left == 0) begin
          busy = 1'b0;
          bx   = (bx + 1) % 8;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b0;
    #1;
    model_clear();
    check_outputs_now();
    check_output("read_en_rst", 36'(bus.read_en), 36'(0));
    repeat (2) apply_stimulus(1'b0, 1'b1, 1'b0);
    reset = 1'b0;
  endtask

  task automatic fill_fifo(input int n);
    for (int i = 0; i < n; i++) fifo.push_back(rand36());
  endtask

  // mode 0: steady; 1: en_proc low for 5 cycles; 2: empty toggling plus stray starts; 3: random
  task automatic run_event(input int mode);
    int cyc;
    bit st;
    bit en;
    bit he;
    cyc = 0;
    apply_stimulus(1'b1, 1'b1, 1'b0);
    while (busy && cyc < 400) begin
      st = 1'b0;
      en = 1'b1;
      he = 1'b0;
      case (mode)
        1: en = !(cyc >= 3 && cyc <= 7);
        2: begin
          he = cyc[0];
          st = (cyc == 2) || (cyc == 5) || (cyc == 11);
        end
        3: begin
          en = ($urandom_range(0, 9) != 0);
          he = ($urandom_range(0, 3) == 0);
          st = ($urandom_range(0, 7) == 0);
        end
        default: ;
      endcase
      apply_stimulus(st, en, he);
      cyc++;
    end
    repeat (2) apply_stimulus(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int cyc;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.en_proc = 1'b0;
    bus.empty   = 1'b1;
    bus.data_in = '0;
    model_clear();
    #1;
    check_outputs_now();
    do_reset();

    $display("[TB] three-stub event");
    fifo.push_back(36'h0_0003_FFFF);
    fifo.push_back(36'h1_2345_6789);
    fifo.push_back(36'hF_FFFF_0000);
    run_event(0);

    $display("[TB] empty event");
    run_event(0);

    $display("[TB] stub limit event");
    fill_fifo(10);
    run_event(0);

    $display("[TB] en_proc pause event");
    fill_fifo(6);
    run_event(1);

    $display("[TB] empty toggling event");
    fill_fifo(6);
    run_event(2);

    $display("[TB] reset mid event");
    fill_fifo(10);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    cyc = 0;
    while (emitted < 3 && cyc < 50) begin
      apply_stimulus(1'b0, 1'b1, 1'b0);
      cyc++;
    end
    do_reset();

    $display("[TB] bx wrap events");
    for (int e = 0; e < 9; e++) begin
      fill_fifo($urandom_range(0, 6));
      run_event(0);
    end

    $display("[TB] random events");
    for (int e = 0; e < 12; e++) begin
      fill_fifo($urandom_range(0, 8));
      run_event(3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
